// File: rtl/xalu_md_sequencer.sv
// Multi-cycle mult/div sequencer for the E-stage XALU: latches operands, holds Busy, commits HI/LO.
// Optional macro XALU_DIV0_TRAP_EN: divide-by-zero raises a Div0 pulse instead of running.
module xalu_md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Start,
    input  logic [2:0]  XAluOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    input  logic        MD_Use_D,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] Out,
    output logic        Div0
);

`ifdef XALU_DIV0_TRAP_EN
    localparam bit LP_TRAP = 1'b1;
`else
    localparam bit LP_TRAP = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LP_MUL_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_busy;
    logic             r_div0;

    logic [63:0]        w_a_ext;
    logic [63:0]        w_b_ext;
    logic [63:0]        w_prod;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;
    logic               w_b_zero;
    logic               w_ovf;
    logic [31:0]        w_div_hi;
    logic [31:0]        w_div_lo;

    // Low 64 bits of the product are exact for both signednesses once extended.
    assign w_a_ext = XAluOp[0] ? {32'b0, A} : {{32{A[31]}}, A};
    assign w_b_ext = XAluOp[0] ? {32'b0, B} : {{32{B[31]}}, B};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_q_s    = $signed(A) / $signed(B);
    assign w_r_s    = $signed(A) % $signed(B);
    assign w_q_u    = A / B;
    assign w_r_u    = A % B;
    assign w_b_zero = (B == 32'h0);
    assign w_ovf    = ~XAluOp[0] & (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF);

    always_comb begin
        w_div_hi = 32'h0;
        w_div_lo = 32'h0;
        if (w_b_zero) begin
            w_div_hi = A;
            w_div_lo = 32'hFFFF_FFFF;
        end else if (w_ovf) begin
            w_div_hi = 32'h0;
            w_div_lo = 32'h8000_0000;
        end else if (XAluOp[0]) begin
            w_div_hi = w_r_u;
            w_div_lo = w_q_u;
        end else begin
            w_div_hi = w_r_s;
            w_div_lo = w_q_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'h0;
            r_lo      <= 32'h0;
            r_pend_hi <= 32'h0;
            r_pend_lo <= 32'h0;
            r_busy    <= 1'b0;
            r_div0    <= 1'b0;
        end else begin
            r_div0 <= 1'b0;
            if (Flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (Start == 2'b01) begin
                            r_state   <= S_MUL;
                            r_busy    <= 1'b1;
                            r_cnt     <= LP_MUL_LAST;
                            r_pend_hi <= w_prod[63:32];
                            r_pend_lo <= w_prod[31:0];
                        end else if (Start == 2'b10) begin
                            if (LP_TRAP && w_b_zero) begin
                                r_div0 <= 1'b1;
                            end else begin
                                r_state   <= S_DIV;
                                r_busy    <= 1'b1;
                                r_cnt     <= LP_DIV_LAST;
                                r_pend_hi <= w_div_hi;
                                r_pend_lo <= w_div_lo;
                            end
                        end else if (Start == 2'b11) begin
                            if (XAluOp == 3'b100) r_hi <= A;
                            else if (XAluOp == 3'b101) r_lo <= A;
                        end
                    end
                    S_MUL, S_DIV: begin
                        if (r_cnt == '0) begin
                            r_hi    <= r_pend_hi;
                            r_lo    <= r_pend_lo;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Busy  = r_busy;
    assign Stall = MD_Use_D & (r_busy | (Start != 2'b00));
    assign Out   = (XAluOp == 3'b110) ? r_hi : r_lo;

`ifdef XALU_DIV0_TRAP_EN
    assign Div0 = r_div0;
`else
    assign Div0 = 1'b0;
`endif

endmodule
